// File: rtl/base_sys_irq_ctrl.sv
// Interrupt aggregator: synchronises peripheral irq lines, latches them as level or
// rising-edge sources, and drives one masked, lowest-index-first irq plus its ID to the CPU.
module base_sys_irq_ctrl #(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq,
  output logic [3:0]         irq_id
);

  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_r;
  logic [NUM_IRQ-1:0] s_d_r;
  logic [NUM_IRQ-1:0] pending_r;
  logic [NUM_IRQ-1:0] mask_r;
  logic [NUM_IRQ-1:0] edge_sel_r;
  logic [NUM_IRQ-1:0] overflow_r;
  logic               irq_r;
  logic [3:0]         irq_id_r;
  logic [15:0]        readdata_r;

  logic [NUM_IRQ-1:0] s_s;
  logic [NUM_IRQ-1:0] rise_s;
  logic [NUM_IRQ-1:0] wd_s;
  logic               wr_s;
  logic [NUM_IRQ-1:0] pend_clr_s;
  logic [NUM_IRQ-1:0] force_s;
  logic [NUM_IRQ-1:0] ovf_clr_s;
  logic [NUM_IRQ-1:0] mode_chg_s;
  logic [NUM_IRQ-1:0] pending_nxt_s;
  logic [NUM_IRQ-1:0] overflow_nxt_s;
  logic [NUM_IRQ-1:0] active_s;
  logic [3:0]         id_nxt_s;
  logic [15:0]        rd_nxt_s;
  logic               unused_s;

  assign s_s      = sync_r[SYNC_STAGES-1];
  assign rise_s   = s_s & ~s_d_r;
  assign wd_s     = writedata[NUM_IRQ-1:0];
  assign unused_s = ^writedata;
  assign wr_s     = chipselect & ~write_n;

  assign pend_clr_s = (wr_s && address == 3'd0) ? wd_s : {NUM_IRQ{1'b0}};
  assign force_s    = (wr_s && address == 3'd4) ? wd_s : {NUM_IRQ{1'b0}};
  assign ovf_clr_s  = (wr_s && address == 3'd5) ? wd_s : {NUM_IRQ{1'b0}};
  assign mode_chg_s = (wr_s && address == 3'd2) ? (wd_s ^ edge_sel_r) : {NUM_IRQ{1'b0}};
  assign active_s   = pending_r & mask_r;

  // Per-bit pending/overflow update; a set always beats a same-cycle W1C
  always_comb begin
    pending_nxt_s  = pending_r;
    overflow_nxt_s = overflow_r;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (mode_chg_s[i]) begin
        pending_nxt_s[i]  = 1'b0;
        overflow_nxt_s[i] = 1'b0;
      end else if (edge_sel_r[i]) begin
        if (rise_s[i] || force_s[i]) begin
          pending_nxt_s[i] = 1'b1;
        end else if (pend_clr_s[i]) begin
          pending_nxt_s[i] = 1'b0;
        end else begin
          pending_nxt_s[i] = pending_r[i];
        end
        if (rise_s[i] && pending_r[i]) begin
          overflow_nxt_s[i] = 1'b1;
        end else if (ovf_clr_s[i]) begin
          overflow_nxt_s[i] = 1'b0;
        end else begin
          overflow_nxt_s[i] = overflow_r[i];
        end
      end else begin
        pending_nxt_s[i] = s_s[i];
        if (ovf_clr_s[i]) begin
          overflow_nxt_s[i] = 1'b0;
        end else begin
          overflow_nxt_s[i] = overflow_r[i];
        end
      end
    end
  end

  // Lowest active index wins; scanning downward leaves the smallest one
  always_comb begin
    id_nxt_s = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active_s[i]) begin
        id_nxt_s = 4'(i);
      end else begin
        id_nxt_s = id_nxt_s;
      end
    end
  end

  // Read mux, captured into readdata on every edge
  always_comb begin
    rd_nxt_s = 16'h0000;
    case (address)
      3'd0:    rd_nxt_s = 16'(pending_r);
      3'd1:    rd_nxt_s = 16'(mask_r);
      3'd2:    rd_nxt_s = 16'(edge_sel_r);
      3'd3:    rd_nxt_s = {irq_r, 11'b000_0000_0000, irq_id_r};
      3'd5:    rd_nxt_s = 16'(overflow_r);
      default: rd_nxt_s = 16'h0000;
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r     <= '0;
      s_d_r      <= {NUM_IRQ{1'b0}};
      pending_r  <= {NUM_IRQ{1'b0}};
      mask_r     <= {NUM_IRQ{1'b0}};
      edge_sel_r <= {NUM_IRQ{1'b0}};
      overflow_r <= {NUM_IRQ{1'b0}};
      irq_r      <= 1'b0;
      irq_id_r   <= 4'd0;
      readdata_r <= 16'h0000;
    end else begin
      sync_r     <= {sync_r[SYNC_STAGES-2:0], irq_in};
      s_d_r      <= s_s;
      pending_r  <= pending_nxt_s;
      overflow_r <= overflow_nxt_s;
      irq_r      <= |active_s;
      irq_id_r   <= id_nxt_s;
      readdata_r <= rd_nxt_s;
      if (wr_s && address == 3'd1) begin
        mask_r <= wd_s;
      end else begin
        mask_r <= mask_r;
      end
      if (wr_s && address == 3'd2) begin
        edge_sel_r <= wd_s;
      end else begin
        edge_sel_r <= edge_sel_r;
      end
    end
  end

  assign readdata = readdata_r;
  assign irq      = irq_r;
  assign irq_id   = irq_id_r;

endmodule

// File: tb/tb_base_sys_irq_ctrl.sv
// Directed bench for base_sys_irq_ctrl: hand-computed expectations checked with immediate assertions.
module tb_base_sys_irq_ctrl;
  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic [7:0]  irq_in;
  logic        irq;
  logic [3:0]  irq_id;

  int errors = 0;
  int checks = 0;

  base_sys_irq_ctrl #(.NUM_IRQ(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .irq_in(irq_in), .irq(irq), .irq_id(irq_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%04h expected=0x%04h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    write_n = 1'b1; chipselect = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [2:0] a, input logic [15:0] exp);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    tick();
    check(tag, readdata, exp);
    chipselect = 1'b0;
  endtask

  task automatic pulse(input int b);
    irq_in[b] = 1'b1;
    tick();
    irq_in[b] = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    reset = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 16'h0000; irq_in = 8'h00;
    repeat (2) tick();
    check("rst_irq", {15'd0, irq}, 16'h0000);
    check("rst_id", {12'd0, irq_id}, 16'h0000);
    check("rst_rd", readdata, 16'h0000);
    reset = 1'b0;
    for (int a = 0; a < 8; a++) rd_check($sformatf("rd0_a%0d", a), 3'(a), 16'h0000);

    // Level source 0: 4-edge latency both ways
    wr(3'd1, 16'h0001);
    irq_in[0] = 1'b1;
    repeat (3) tick();
    check("lvl_rise_early", {15'd0, irq}, 16'h0000);
    tick();
    check("lvl_rise_4", {15'd0, irq}, 16'h0001);
    rd_check("lvl_active", 3'd3, 16'h8000);
    irq_in[0] = 1'b0;
    repeat (3) tick();
    check("lvl_fall_early", {15'd0, irq}, 16'h0001);
    tick();
    check("lvl_fall_4", {15'd0, irq}, 16'h0000);

    // Edge sources 2 and 5
    wr(3'd1, 16'h00FF);
    wr(3'd2, 16'h0024);
    pulse(5);
    check("edge_id5", {12'd0, irq_id}, 16'h0005);
    pulse(2);
    rd_check("edge_pend", 3'd0, 16'h0024);
    check("edge_id2", {12'd0, irq_id}, 16'h0002);
    wr(3'd0, 16'h0004);
    tick();
    check("w1c_id5", {12'd0, irq_id}, 16'h0005);
    check("w1c_irq1", {15'd0, irq}, 16'h0001);
    wr(3'd0, 16'h0020);
    tick();
    check("w1c_irq0", {15'd0, irq}, 16'h0000);

    // Overflow on edge source 3
    wr(3'd2, 16'h002C);
    pulse(3);
    rd_check("ovf_none", 3'd5, 16'h0000);
    pulse(3);
    rd_check("ovf_set", 3'd5, 16'h0008);
    wr(3'd5, 16'h0008);
    rd_check("ovf_w1c", 3'd5, 16'h0000);
    irq_in[3] = 1'b1;
    tick();
    irq_in[3] = 1'b0;
    tick();
    wr(3'd5, 16'h0008);
    tick();
    rd_check("ovf_set_wins", 3'd5, 16'h0008);

    // FORCE
    wr(3'd0, 16'h0008);
    tick();
    check("force_pre_irq0", {15'd0, irq}, 16'h0000);
    wr(3'd2, 16'h003C);
    wr(3'd4, 16'h0010);
    tick();
    check("force_irq", {15'd0, irq}, 16'h0001);
    check("force_id", {12'd0, irq_id}, 16'h0004);
    rd_check("force_pend", 3'd0, 16'h0010);
    wr(3'd4, 16'h0001);
    tick();
    rd_check("force_lvl_ign", 3'd0, 16'h0010);
    rd_check("force_rd0", 3'd4, 16'h0000);
    rd_check("esel_rd", 3'd2, 16'h003C);

    // Reset mid-operation
    rd_check("pre_rst_pend", 3'd0, 16'h0010);
    reset = 1'b1;
    #1;
    check("mid_rst_irq", {15'd0, irq}, 16'h0000);
    check("mid_rst_id", {12'd0, irq_id}, 16'h0000);
    check("mid_rst_rd", readdata, 16'h0000);
    tick();
    reset = 1'b0;
    for (int a = 0; a < 8; a++) rd_check($sformatf("rd1_a%0d", a), 3'(a), 16'h0000);
    irq_in = 8'h11;
    repeat (6) tick();
    check("post_rst_noirq", {15'd0, irq}, 16'h0000);
    rd_check("post_rst_pend", 3'd0, 16'h0011);
    wr(3'd1, 16'h0010);
    tick();
    check("post_rst_irq", {15'd0, irq}, 16'h0001);
    check("post_rst_id", {12'd0, irq_id}, 16'h0004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/base_sys_irq_ctrl.md
Name: base_sys_irq_ctrl

Overview:
Interrupt aggregator that sits directly downstream of the system timer and peer peripherals. It consumes their single-bit irq outputs and presents one masked, prioritised interrupt line plus a source ID to the Nios II core. Software reads, masks and acknowledges sources through a 16-bit Avalon-MM slave, using the same 1-cycle registered-read style as the timer.

Parameters:
NUM_IRQ, 8, number of interrupt sources (1..16)
SYNC_STAGES, 2, synchroniser depth on each irq_in bit (>=2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-high
address  in  3  register select
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  16  write data
readdata  out  16  registered read data
irq_in  in  NUM_IRQ  source interrupt lines; bit 0 connects to the sys_timer irq
irq  out  1  aggregated interrupt to the CPU
irq_id  out  4  index of the highest-priority active source

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high. All flops clear on reset, including synchronisers, pending, mask, edge_sel, overflow, irq, irq_id and readdata (all 0).
- Synchronisation: irq_in passes through SYNC_STAGES flops; the last stage is s. A registered copy s_d drives edge detection (rise = s & ~s_d).
- Register map (wr = chipselect & ~write_n):
  - 0 PENDING: R. W1C on edge-mode bits; writes to level-mode bits are ignored.
  - 1 MASK: RW. 1 = enabled.
  - 2 EDGE_SEL: RW. 1 = rising-edge source, 0 = level source.
  - 3 ACTIVE: RO. Reads {valid, 11'b0, id[3:0]}.
  - 4 FORCE: W only. Each 1 sets pending on the corresponding edge-mode bit. Reads 0.
  - 5 OVERFLOW: R, W1C.
  - 6, 7: read 0, writes ignored.
- Level bit: pending[i] <= s[i] every cycle.
- Edge bit:
  - pending set on rise or FORCE; cleared by W1C.
  - Set wins over a same-cycle clear.
  - Rise while pending[i] is already 1 sets overflow[i]. overflow set also wins over a same-cycle W1C.
- EDGE_SEL write: pending and overflow are cleared for every bit whose mode changes. Normal evaluation resumes the next cycle.
- Prioritisation:
  - active = pending & mask.
  - irq <= |active (registered).
  - irq_id <= lowest set index of active, else 0.
  - ACTIVE.valid equals irq.
- Latency: irq_in rising to irq high takes SYNC_STAGES+2 clk edges. W1C or mask write to irq low takes 2 edges (register update, then irq flop).
- Read path: readdata <= mux(address) every cycle, so data is valid 1 cycle after the address is presented. Reads have no side effects.
- Width rules: bits >= NUM_IRQ of PENDING, MASK, EDGE_SEL and OVERFLOW read 0 and ignore writes. writedata[15:NUM_IRQ] is don't-care.
- Reset mid-operation: all state is lost. After deassertion the synchronisers start at 0, so an irq_in held high appears as a rising edge on edge-mode sources once EDGE_SEL is reprogrammed. Software must clear PENDING after configuration.

Test Plan:
- Reset release, irq_in=0 -> irq=0, irq_id=0. Reading each address 0..7 returns 0x0000 one cycle after the address is presented.
- MASK=0x0001, level mode, raise irq_in[0] (timer irq) -> irq=1 exactly SYNC_STAGES+2=4 edges later with ACTIVE=0x8000. Drop irq_in[0] -> irq=0 four edges later.
- MASK=0x00FF, EDGE_SEL=0x0024, pulse irq_in[5] and irq_in[2] for 1 cycle each -> PENDING=0x0024, irq_id=2. Write PENDING=0x0004 -> irq_id=5. Write 0x0020 -> irq=0.
- Edge source 3 pending, pulse irq_in[3] again -> OVERFLOW=0x0008. W1C to OVERFLOW in the same cycle as a new rise -> OVERFLOW stays 0x0008.
- FORCE=0x0010 with EDGE_SEL[4]=1, MASK[4]=1 -> PENDING=0x0010, irq=1. FORCE=0x0001 with bit 0 in level mode -> no change.
- Assert reset with irq=1 and pending nonzero -> irq, irq_id, readdata and all registers read 0 immediately. No irq after release until MASK is rewritten.
